// File: rtl/qupls_merge_pkg.sv
// Shared types and width helpers for the response merger and its channel FIFOs.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package qupls_merge_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Width of a channel index. At least one bit, so a 1-channel build still elaborates.
    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Width of an occupancy count. The extra bit lets the count represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/qupls_resp_fifo.sv
// Per-channel response FIFO with a show-ahead head (dout is the oldest entry).
// Latency: a push is visible on dout/empty the cycle after the push edge.
// Backpressure: push is ignored when full, unless pop happens in the same cycle.
// Ports: push/din write, pop/dout read, full/empty/count status.
module qupls_resp_fifo
    import qupls_merge_pkg::*;
#(
    parameter int WIDTH = 300,
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             wr_en;
    logic             rd_en;

    // A full FIFO frees its head slot on the same edge, so a simultaneous push fits.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked entirely by cnt.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/qupls_resp_merge.sv
// Merges CHANNELS response sources onto one registered response bus (RR or fixed priority).
// Latency: 2 cycles from resp_valid_i to resp_valid_o (push edge, then pop edge).
// Backpressure: resp_ready_i=0 holds the output register; FIFOs absorb, overflow drops and sets ovf_o.
// Ports: resp_valid_i/resp_i per-channel inputs; resp_o/resp_valid_o/resp_chan_o/resp_ready_i merged output;
//        ovf_o/ovf_clr_i sticky overflow flags; busy_o any work pending.
module qupls_resp_merge
    import qupls_merge_pkg::*;
#(
    parameter int    CHANNELS = 4,
    parameter int    RESP_W   = 300,
    parameter int    DEPTH    = 4,
    parameter string ARB_MODE = "RR"
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [CHANNELS-1:0]           resp_valid_i,
    input  logic [CHANNELS*RESP_W-1:0]    resp_i,
    output logic [RESP_W-1:0]             resp_o,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [chan_w(CHANNELS)-1:0]   resp_chan_o,
    output logic [CHANNELS-1:0]           ovf_o,
    input  logic [CHANNELS-1:0]           ovf_clr_i,
    output logic                          busy_o
);

    localparam int        CHAN_W = chan_w(CHANNELS);
    localparam int        CNT_W  = cnt_w(DEPTH);
    localparam arb_mode_e MODE   = (ARB_MODE == "FIXED") ? ARB_FIXED : ARB_RR;

    logic [RESP_W-1:0]   head [CHANNELS];
    logic [CNT_W-1:0]    cnt  [CHANNELS];
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] occupied;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] ovf_set;
    logic [CHAN_W-1:0]   grant;
    logic                grant_vld;
    logic [CHAN_W-1:0]   last_grant;
    logic                free;
    logic                take;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        qupls_resp_fifo #(
            .WIDTH (RESP_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .push  (resp_valid_i[k]),
            .pop   (pop[k]),
            .din   (resp_i[k*RESP_W +: RESP_W]),
            .dout  (head[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .count (cnt[k])
        );

        assign occupied[k] = |cnt[k];
        // A word arriving at a full FIFO is lost only if no slot opens on this edge.
        assign ovf_set[k]  = resp_valid_i[k] & full[k] & ~pop[k];
    end

    // Scan all channels starting from the highest-priority one; first non-empty wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (MODE == ARB_FIXED) idx = i;
            else                   idx = int'(last_grant) + 1 + i;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant     = CHAN_W'(idx);
            end
        end
    end

    assign free = !resp_valid_o || resp_ready_i;
    assign take = free && grant_vld;
    assign pop  = take ? (CHANNELS'(1) << grant) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_o       <= '0;
            resp_valid_o <= 1'b0;
            resp_chan_o  <= '0;
            // Starting just below channel 0 gives channel 0 the first turn.
            last_grant   <= CHAN_W'(CHANNELS - 1);
            ovf_o        <= '0;
        end else begin
            if (free) begin
                resp_valid_o <= grant_vld;
                if (grant_vld) begin
                    resp_o      <= head[grant];
                    resp_chan_o <= grant;
                    last_grant  <= grant;
                end
            end
            // A new overflow in the same cycle as its clear keeps the flag set.
            ovf_o <= (ovf_o & ~ovf_clr_i) | ovf_set;
        end
    end

    assign busy_o = (|occupied) | resp_valid_o;

endmodule

// File: tb/tb_qupls_resp_merge.sv
// Bench for qupls_resp_merge: directed vector table, hand sequences, and a queue-based random model.
// Latency: n/a.
// Backpressure: driven from the bench on resp_ready_i.
module tb_qupls_resp_merge;

    localparam int CH = 4;
    localparam int RW = 300;
    localparam int DP = 4;

    logic            clk;
    logic            rst;
    logic [CH-1:0]   resp_valid_i;
    logic [CH*RW-1:0] resp_i;
    logic            resp_ready_i;
    logic [CH-1:0]   ovf_clr_i;

    logic [RW-1:0]   rr_resp,  fx_resp;
    logic            rr_vld,   fx_vld;
    logic [1:0]      rr_chan,  fx_chan;
    logic [CH-1:0]   rr_ovf,   fx_ovf;
    logic            rr_busy,  fx_busy;

    int n_chk  = 0;
    int n_pass = 0;

    qupls_resp_merge #(.CHANNELS(CH), .RESP_W(RW), .DEPTH(DP), .ARB_MODE("RR")) dut_rr (
        .clk_i(clk), .rst_i(rst), .resp_valid_i(resp_valid_i), .resp_i(resp_i),
        .resp_o(rr_resp), .resp_valid_o(rr_vld), .resp_ready_i(resp_ready_i),
        .resp_chan_o(rr_chan), .ovf_o(rr_ovf), .ovf_clr_i(ovf_clr_i), .busy_o(rr_busy)
    );

    qupls_resp_merge #(.CHANNELS(CH), .RESP_W(RW), .DEPTH(DP), .ARB_MODE("FIXED")) dut_fx (
        .clk_i(clk), .rst_i(rst), .resp_valid_i(resp_valid_i), .resp_i(resp_i),
        .resp_o(fx_resp), .resp_valid_o(fx_vld), .resp_ready_i(resp_ready_i),
        .resp_chan_o(fx_chan), .ovf_o(fx_ovf), .ovf_clr_i(ovf_clr_i), .busy_o(fx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- comparison helpers ----------------
    task automatic cmp(input string nm, input string fld, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s %s: got %0h expected %0h", nm, fld, act, exp);
    endtask

    // m=0 selects the round-robin instance, m=1 the fixed-priority one.
    task automatic chk(input string nm, input int m, input logic ev, input logic [RW-1:0] ed,
                       input int ec, input logic [3:0] eo, input logic eb);
        logic av; logic [RW-1:0] ad; int ac; logic [3:0] ao; logic ab;
        if (m == 0) begin av = rr_vld; ad = rr_resp; ac = int'(rr_chan); ao = rr_ovf; ab = rr_busy; end
        else        begin av = fx_vld; ad = fx_resp; ac = int'(fx_chan); ao = fx_ovf; ab = fx_busy; end
        cmp(nm, "resp_valid_o", RW'(av), RW'(ev));
        if (ev) begin
            cmp(nm, "resp_o", ad, ed);
            cmp(nm, "resp_chan_o", RW'(ac), RW'(ec));
        end
        cmp(nm, "ovf_o", RW'(ao), RW'(eo));
        cmp(nm, "busy_o", RW'(ab), RW'(eb));
    endtask

    // Channel k receives byte (base+k); one clock edge is consumed, outputs settle 1ns later.
    task automatic drive(input logic [3:0] vld, input logic [7:0] base, input logic rdy, input logic [3:0] clr);
        logic [7:0] b;
        resp_valid_i = vld;
        for (int k = 0; k < CH; k++) begin
            b = base + 8'(k);
            resp_i[k*RW +: RW] = {292'd0, b};
        end
        resp_ready_i = rdy;
        ovf_clr_i    = clr;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] vld;
        logic [7:0] base;
        logic       ev;
        logic [7:0] ed;
        int         ec;
        logic       eb;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic [3:0] vld, input logic [7:0] base, input logic ev,
                                input logic [7:0] ed, input int ec, input logic eb);
        vec_t v;
        v.vld = vld; v.base = base; v.ev = ev; v.ed = ed; v.ec = ec; v.eb = eb;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Per instance: one queue per channel, the output register contents, the last winner, overflow flags.
    logic [RW-1:0] mq [2*CH][$];
    logic          mv   [2];
    logic [RW-1:0] md   [2];
    int            mc   [2];
    int            mlg  [2];
    logic [3:0]    movf [2];

    task automatic model_reset();
        for (int i = 0; i < 2*CH; i++) mq[i].delete();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; md[m] = '0; mc[m] = 0; mlg[m] = CH - 1; movf[m] = '0;
        end
    endtask

    // Advance both models by one clock edge using the inputs currently applied.
    task automatic model_step();
        int         win;
        int         c;
        logic [3:0] set;
        for (int m = 0; m < 2; m++) begin
            if (!mv[m] || resp_ready_i) begin
                win = -1;
                for (int i = 0; i < CH; i++) begin
                    c = (m == 0) ? (mlg[m] + 1 + i) % CH : i;
                    if (win < 0 && mq[m*CH + c].size() > 0) win = c;
                end
                if (win >= 0) begin
                    md[m]  = mq[m*CH + win].pop_front();
                    mc[m]  = win;
                    mlg[m] = win;
                    mv[m]  = 1'b1;
                end else begin
                    mv[m] = 1'b0;
                end
            end
            set = '0;
            for (int k = 0; k < CH; k++) begin
                if (resp_valid_i[k]) begin
                    if (mq[m*CH + k].size() < DP) mq[m*CH + k].push_back(resp_i[k*RW +: RW]);
                    else set[k] = 1'b1;
                end
            end
            movf[m] = (movf[m] & ~ovf_clr_i) | set;
        end
    endtask

    function automatic logic model_busy(input int m);
        logic b;
        b = mv[m];
        for (int k = 0; k < CH; k++) if (mq[m*CH + k].size() > 0) b = 1'b1;
        return b;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        tbl[0]  = mk(4'b1111, 8'h10, 0, 8'h00, 0, 1);
        tbl[1]  = mk(4'b0000, 8'h00, 1, 8'h10, 0, 1);
        tbl[2]  = mk(4'b0000, 8'h00, 1, 8'h11, 1, 1);
        tbl[3]  = mk(4'b0000, 8'h00, 1, 8'h12, 2, 1);
        tbl[4]  = mk(4'b0000, 8'h00, 1, 8'h13, 3, 1);
        tbl[5]  = mk(4'b0000, 8'h00, 0, 8'h00, 0, 0);
        tbl[6]  = mk(4'b0010, 8'hA4, 0, 8'h00, 0, 1);
        tbl[7]  = mk(4'b0000, 8'h00, 1, 8'hA5, 1, 1);
        tbl[8]  = mk(4'b0000, 8'h00, 0, 8'h00, 0, 0);
        tbl[9]  = mk(4'b1111, 8'h20, 0, 8'h00, 0, 1);
        tbl[10] = mk(4'b0000, 8'h00, 1, 8'h22, 2, 1);
        tbl[11] = mk(4'b0000, 8'h00, 1, 8'h23, 3, 1);
        tbl[12] = mk(4'b0000, 8'h00, 1, 8'h20, 0, 1);
        tbl[13] = mk(4'b0000, 8'h00, 1, 8'h21, 1, 1);
        tbl[14] = mk(4'b0000, 8'h00, 0, 8'h00, 0, 0);

        rst = 1'b1;
        resp_valid_i = '0; resp_i = '0; resp_ready_i = 1'b0; ovf_clr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) chk("reset", m, 1'b0, '0, 0, 4'b0000, 1'b0);
        cmp("reset", "rr resp_o", rr_resp, '0);
        cmp("reset", "rr resp_chan_o", RW'(rr_chan), '0);
        rst = 1'b0;

        // Round-robin fairness from reset, single response, then fairness after a ch1 grant.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].vld, tbl[i].base, 1'b1, 4'b0000);
            chk($sformatf("tbl%0d", i), 0, tbl[i].ev, RW'(tbl[i].ed), tbl[i].ec, 4'b0000, tbl[i].eb);
        end

        // Overflow on channel 2: word 1 in the output register, 2..5 queued, 6 dropped.
        for (int w = 1; w <= 6; w++) begin
            drive(4'b0100, 8'(w - 2), 1'b0, 4'b0000);
            if (w == 5) chk("ovf_w5", 0, 1'b1, RW'(1), 2, 4'b0000, 1'b1);
        end
        chk("ovf_w6", 0, 1'b1, RW'(1), 2, 4'b0100, 1'b1);
        for (int w = 2; w <= 5; w++) begin
            drive(4'b0000, 8'h00, 1'b1, 4'b0000);
            chk($sformatf("ovf_drain%0d", w), 0, 1'b1, RW'(w), 2, 4'b0100, 1'b1);
        end
        drive(4'b0000, 8'h00, 1'b1, 4'b0000);
        chk("ovf_empty", 0, 1'b0, '0, 0, 4'b0100, 1'b0);
        drive(4'b0000, 8'h00, 1'b1, 4'b0100);
        chk("ovf_clr", 0, 1'b0, '0, 0, 4'b0000, 1'b0);

        // Set and clear of bit 2 in the same cycle; clearing unset bit 0 changes nothing.
        for (int w = 8'h11; w <= 8'h15; w++) drive(4'b0100, 8'(w - 2), 1'b0, 4'b0000);
        chk("full_no_ovf", 0, 1'b1, RW'(8'h11), 2, 4'b0000, 1'b1);
        drive(4'b0100, 8'h14, 1'b0, 4'b0101);
        chk("set_over_clr", 0, 1'b1, RW'(8'h11), 2, 4'b0100, 1'b1);
        drive(4'b0000, 8'h00, 1'b0, 4'b0100);
        chk("clr_alone", 0, 1'b1, RW'(8'h11), 2, 4'b0000, 1'b1);
        for (int w = 8'h12; w <= 8'h15; w++) begin
            drive(4'b0000, 8'h00, 1'b1, 4'b0000);
            chk($sformatf("soc_drain%0h", w), 0, 1'b1, RW'(w), 2, 4'b0000, 1'b1);
        end
        drive(4'b0000, 8'h00, 1'b1, 4'b0000);
        chk("soc_empty", 0, 1'b0, '0, 0, 4'b0000, 1'b0);

        // Back-pressure hold: 0x77 stays put while channel 0 keeps filling its FIFO.
        drive(4'b0001, 8'h77, 1'b0, 4'b0000);
        for (int w = 8'h78; w <= 8'h7B; w++) begin
            drive(4'b0001, 8'(w), 1'b0, 4'b0000);
            chk($sformatf("hold%0h", w), 0, 1'b1, RW'(8'h77), 0, 4'b0000, 1'b1);
        end
        drive(4'b0000, 8'h00, 1'b0, 4'b0000);
        chk("hold_idle", 0, 1'b1, RW'(8'h77), 0, 4'b0000, 1'b1);
        drive(4'b0001, 8'h7C, 1'b0, 4'b0000);
        chk("hold_full", 0, 1'b1, RW'(8'h77), 0, 4'b0001, 1'b1);
        for (int w = 8'h78; w <= 8'h7B; w++) begin
            drive(4'b0000, 8'h00, 1'b1, 4'b0000);
            chk($sformatf("bp_drain%0h", w), 0, 1'b1, RW'(w), 0, 4'b0001, 1'b1);
        end
        drive(4'b0000, 8'h00, 1'b1, 4'b0000);
        chk("bp_empty", 0, 1'b0, '0, 0, 4'b0001, 1'b0);

        // Reset mid-burst, asserted between clock edges.
        drive(4'b0111, 8'h30, 1'b0, 4'b0000);
        drive(4'b0000, 8'h00, 1'b0, 4'b0000);
        chk("pre_rst", 0, 1'b1, RW'(8'h31), 1, 4'b0001, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) chk($sformatf("async_rst%0d", m), m, 1'b0, '0, 0, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 8'h00, 1'b1, 4'b0000);
            chk($sformatf("post_rst%0d", i), 0, 1'b0, '0, 0, 4'b0000, 1'b0);
        end

        // Fixed priority: channels 0 and 3 push two words each; channel 0 drains first.
        drive(4'b1001, 8'h40, 1'b1, 4'b0000);
        chk("fx_push", 1, 1'b0, '0, 0, 4'b0000, 1'b1);
        drive(4'b1001, 8'h50, 1'b1, 4'b0000);
        chk("fx0", 1, 1'b1, RW'(8'h40), 0, 4'b0000, 1'b1);
        drive(4'b0000, 8'h00, 1'b1, 4'b0000);
        chk("fx1", 1, 1'b1, RW'(8'h50), 0, 4'b0000, 1'b1);
        drive(4'b0000, 8'h00, 1'b1, 4'b0000);
        chk("fx2", 1, 1'b1, RW'(8'h43), 3, 4'b0000, 1'b1);
        drive(4'b0000, 8'h00, 1'b1, 4'b0000);
        chk("fx3", 1, 1'b1, RW'(8'h53), 3, 4'b0000, 1'b1);
        drive(4'b0000, 8'h00, 1'b1, 4'b0000);
        chk("fx_empty", 1, 1'b0, '0, 0, 4'b0000, 1'b0);

        // Random traffic on both instances against the queue model.
        rst = 1'b1;
        resp_valid_i = '0; ovf_clr_i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int k = 0; k < CH; k++) begin
                resp_valid_i[k] = ($urandom_range(0, 9) < 3);
                for (int j = 0; j < 10; j++) resp_i[k*RW +: RW] = {resp_i[k*RW +: RW-32], 32'($urandom)};
            end
            if ((cyc % 100) < 30) resp_ready_i = ($urandom_range(0, 4) == 0);
            else                  resp_ready_i = ($urandom_range(0, 3) != 0);
            ovf_clr_i = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            model_step();
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++)
                chk($sformatf("rnd%0d_m%0d", cyc, m), m, mv[m], md[m], mc[m], movf[m], model_busy(m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qupls_resp_merge.md
Name: qupls_resp_merge

Overview:
- Parametrised successor to the fixed 4-channel response buffer used in the MPU subsystem.
- Merges CHANNELS independent response sources (PIT, MSI, PIC, memory, etc.) onto one response bus returning to the CPU.
- Each channel has its own FIFO, so simultaneous responses are never lost while the FIFO has room.
- Adds selectable round-robin or fixed-priority arbitration, downstream back-pressure and sticky per-channel overflow flags.

Parameters:
- CHANNELS, 4: number of response sources, 2..16.
- RESP_W, 300: width in bits of one packed response word (opaque payload).
- DEPTH, 4: entries per channel FIFO; power of two, 2..32.
- ARB_MODE, "RR": "RR" = round-robin; "FIXED" = lowest channel index wins.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- resp_valid_i  in  CHANNELS  per-channel response strobe (the source's ack).
- resp_i  in  CHANNELS*RESP_W  per-channel response words; channel k occupies bits [k*RESP_W +: RESP_W].
- resp_o  out  RESP_W  merged response word.
- resp_valid_o  out  1  resp_o holds a valid response.
- resp_ready_i  in  1  downstream accepts resp_o this cycle.
- resp_chan_o  out  $clog2(CHANNELS)  channel index of the word in resp_o.
- ovf_o  out  CHANNELS  sticky per-channel overflow flags.
- ovf_clr_i  in  CHANNELS  clear the matching ovf_o bits.
- busy_o  out  1  any FIFO non-empty or resp_valid_o high.

Behaviour:
- Reset (async, rst_i=1):
  - all FIFOs empty; pointers and counts 0.
  - resp_valid_o=0, resp_o=0, resp_chan_o=0, ovf_o=0, busy_o=0.
  - round-robin pointer set so channel 0 has top priority first.
  - reset asserted mid-operation discards all queued responses immediately.
- Push, per channel k, on a rising edge:
  - If resp_valid_i[k]=1 and the FIFO is not full, write resp_i slice k.
  - A full FIFO still accepts if it pops in the same cycle (count stays DEPTH).
  - If full and not popping, drop the word and set ovf_o[k]=1.
- Output register:
  - It is "free" when resp_valid_o=0 or resp_ready_i=1.
  - When free and any FIFO is non-empty, the arbiter grants one channel. Its head is popped into resp_o and resp_chan_o, and resp_valid_o=1 next cycle.
  - When free and all FIFOs are empty, resp_valid_o=0 next cycle.
  - When not free, resp_o, resp_chan_o and resp_valid_o hold (stall).
- Latency: resp_valid_i in cycle N gives resp_valid_o in cycle N+2 (push edge, then pop edge); no bypass path.
- Throughput: one response per cycle when resp_ready_i is held high.
- RR arbitration:
  - Search starts at (last_grant+1) mod CHANNELS.
  - last_grant updates only on a grant.
  - Worst-case wait for a non-empty channel is CHANNELS-1 grants.
- FIXED arbitration: lowest-index non-empty channel wins; starvation of high indices is permitted.
- Channel ordering: responses from one channel leave in arrival order. No ordering guarantee across channels.
- ovf_o:
  - set wins over clear when both occur for the same bit in one cycle.
  - ovf_clr_i of a bit that is not set has no effect.
- Count arithmetic: counts are $clog2(DEPTH)+1 bits; read and write pointers wrap modulo DEPTH.
- busy_o is combinational from counts and resp_valid_o.

Decomposition:
- Shared package qupls_merge_pkg holds:
  - localparams CHAN_W=$clog2(CHANNELS) and CNT_W=$clog2(DEPTH)+1, supplied as functions for reuse;
  - enum arb_mode_e {ARB_RR, ARB_FIXED} mapped from ARB_MODE.
- Sub-module qupls_resp_fifo (parameters WIDTH, DEPTH):
  - async-reset synchronous FIFO;
  - ports push, pop, din, dout (head, show-ahead), full, empty, count.
- The top module holds: a CHANNELS-wide generate of FIFOs, the arbiter, the output register and the ovf logic.

Test Plan:
- Single response: reset, then resp_valid_i=4'b0010 for one cycle with word 0xA5 on channel 1. Required: resp_valid_o=1 two cycles later, resp_o=0xA5, resp_chan_o=1, then resp_valid_o=0 the following cycle.
- RR fairness: CHANNELS=4, resp_ready_i=1, all four channels strobe together with words 0x10, 0x11, 0x12, 0x13. Required: output order is ch0, ch1, ch2, ch3 on consecutive cycles. Repeat with the last grant on ch1: the next simultaneous burst outputs ch2, ch3, ch0, ch1.
- FIXED mode: ARB_MODE="FIXED", channels 3 and 0 each push 2 words simultaneously. Required: output order is ch0, ch0, ch3, ch3.
- Overflow: DEPTH=4, resp_ready_i=0, channel 2 strobes 6 consecutive cycles with words 1..6. Required: the output register holds word 1 and the FIFO holds 2..5; word 6 is dropped and ovf_o[2]=1. Then raise resp_ready_i: the outputs are 1, 2, 3, 4, 5. Pulse ovf_clr_i[2]: ovf_o[2]=0. Also check set-over-clear priority when both occur in the same cycle.
- Back-pressure hold: resp_valid_o=1 with resp_o=0x77 and resp_ready_i=0 for 5 cycles while channel 0 keeps pushing. Required: resp_o stays 0x77 and resp_chan_o stays stable; no entries are lost until the FIFO is full.
- Reset mid-burst: 3 entries queued and resp_valid_o=1, then rst_i asserted asynchronously between clock edges. Required: resp_valid_o=0, busy_o=0 and ovf_o=0 immediately; after release, no stale words appear on resp_o.
